// File: rtl/data_memory_sized_if.sv
// data_memory_sized_if: request/response handshake bundle between the core memory stage and the data RAM.
interface data_memory_sized_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_sized.sv
// data_memory_sized: word RAM with valid/ready handshake, sized little-endian accesses, load extension and wait states.
module data_memory_sized #(
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_sized_if.slave   bus
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d, uns_q, uns_d, valid_q, valid_d, err_q, err_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]           mem [DEPTH];
  logic                  live, a_we, a_uns, err, access, wr;
  logic [1:0]            a_size;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata, word, ld, st_data;
  logic [IW-1:0]         idx;
  logic [3:0]            be;
  logic [7:0]            lb;
  logic [15:0]           lh;
  // With no wait states the access happens on the accept edge, so it uses the live request.
  always_comb begin
    live    = state_q == IDLE;
    a_we    = live ? bus.req_we : we_q;
    a_uns   = live ? bus.req_unsigned : uns_q;
    a_size  = live ? bus.req_size : size_q;
    a_addr  = live ? bus.req_addr : addr_q;
    a_wdata = live ? bus.req_wdata : wdata_q;
    idx     = a_addr[IW+1:2];
    word    = mem[idx];
    lb      = 8'(word >> {a_addr[1:0], 3'b000});
    lh      = a_addr[1] ? word[31:16] : word[15:0];
    err     = a_size == 2'b11 || (a_size == 2'b01 && a_addr[0]) ||
              (a_size == 2'b10 && a_addr[1:0] != '0) || (a_addr >> (IW + 2)) != '0;
    ld      = a_size == 2'b00 ? {{24{lb[7] & ~a_uns}}, lb} :
              a_size == 2'b01 ? {{16{lh[15] & ~a_uns}}, lh} : word;
    be      = a_size == 2'b00 ? 4'b0001 << a_addr[1:0] :
              a_size == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_data = a_size == 2'b00 ? {4{a_wdata[7:0]}} :
              a_size == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
    access  = (live && bus.req_valid && WAIT_STATES == 0) || (state_q == WAIT && cnt_q == '0);
    wr      = access && a_we && !err;
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (live && bus.req_valid) begin
      we_d    = bus.req_we;
      uns_d   = bus.req_unsigned;
      size_d  = bus.req_size;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      cnt_d   = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
      state_d = WAIT_STATES == 0 ? RESP : WAIT;
    end
    if (state_q == WAIT) cnt_d = cnt_q - 4'd1;
    if (access) begin
      state_d = RESP;
      valid_d = 1'b1;
      err_d   = err;
      rdata_d = (a_we || err) ? 32'd0 : ld;
    end
    if (state_q == RESP && bus.resp_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  // Contents are never cleared; reset only blocks a write on an edge it overlaps.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = err_q;
endmodule
